// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: RV32IM IF stage with PC, imem handshake, IF/ID register,
// one-entry stall skid buffer and branch redirects that may land mid-fetch.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_OUT,
    output logic [31:0] PC_PLUS4,
    output logic        VALID
);
    localparam logic [1:0] FETCH    = 2'd0;
    localparam logic [1:0] HOLD     = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;
    logic [1:0]  state;
    logic        rst_q;
    logic [31:0] pc, pend_target, buf_instr, buf_pc;
    logic        fc;
    logic [31:0] target;
    assign IMEM_READ    = !rst_q && state != HOLD;
    assign IMEM_ADDRESS = pc;
    assign fc           = IMEM_READ && !IMEM_BUSYWAIT;
    assign target       = {BRANCH_TARGET[31:2], 2'b00};
    always_ff @(posedge CLK) begin
        rst_q <= RESET;
        if (RESET) begin
            pc          <= RESET_PC;
            state       <= FETCH;
            pend_target <= '0;
            buf_instr   <= NOP_INSTR;
            buf_pc      <= '0;
            INSTRUCTION <= NOP_INSTR;
            PC_OUT      <= '0;
            PC_PLUS4    <= 32'd4;
            VALID       <= 1'b0;
        end else if (BRANCH_TAKEN) begin
            INSTRUCTION <= NOP_INSTR;
            VALID       <= 1'b0;
            // a pending fetch must keep its address until memory answers
            if (IMEM_READ && IMEM_BUSYWAIT) begin
                pend_target <= target;
                state       <= REDIRECT;
            end else begin
                pc    <= target;
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (STALL) begin
                        if (fc) begin
                            buf_instr <= IMEM_READDATA;
                            buf_pc    <= pc;
                            pc        <= pc + 32'd4;
                            state     <= HOLD;
                        end
                    end else if (fc) begin
                        INSTRUCTION <= IMEM_READDATA;
                        PC_OUT      <= pc;
                        PC_PLUS4    <= pc + 32'd4;
                        VALID       <= 1'b1;
                        pc          <= pc + 32'd4;
                    end else begin
                        INSTRUCTION <= NOP_INSTR;
                        VALID       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!STALL) begin
                        INSTRUCTION <= buf_instr;
                        PC_OUT      <= buf_pc;
                        PC_PLUS4    <= buf_pc + 32'd4;
                        VALID       <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    INSTRUCTION <= NOP_INSTR;
                    VALID       <= 1'b0;
                    if (fc) begin
                        pc    <= pend_target;
                        state <= FETCH;
                    end
                end
            endcase
        end
    end
endmodule
